fb_arbiter: RTL
===============

Name: fb_arbiter

Overview:
Owns the single-port 1024x8 framebuffer RAM and shares it between two users: the OLED scan engine, which reads one byte per pixelAddress change, and a drawing/writer client, which writes bytes.
Adds a hardware clear-screen sequencer and a frame-boundary tick so writers can avoid tearing.
Sits between the screen driver's pixelAddress/pixelData pair and the frame RAM instance.

Parameters:
FB_DEPTH, 1024, framebuffer bytes (128x64/8); address width fixed at 10.
WR_FIFO_DEPTH, 4, write-buffer entries; used only with FB_WRITE_FIFO_EN; power of two, at least 2.

Ports:
clk  in  1  system clock
rst_btn  in  1  synchronous, active-high reset
dispAddress  in  10  byte address requested by the scan engine
dispData  out  8  registered byte for dispAddress
wrValid  in  1  writer request valid
wrReady  out  1  writer request accepted this cycle when wrValid is also high
wrAddr  in  10  write address
wrData  in  8  write data
clrReq  in  1  single-cycle pulse: fill the whole buffer with clrValue
clrValue  in  8  fill byte, sampled when clrReq is accepted
busy  out  1  clear in progress, or pending under FB_WRITE_FIFO_EN
frameTick  out  1  one-cycle pulse at start of a scan frame
memAddr  out  10  RAM address (combinational from the arbiter decision)
memWe  out  1  RAM write enable
memWdata  out  8  RAM write data
memRdata  in  8  RAM read data, valid one cycle after the read address

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high on rst_btn.
- Reset values: dispData=0, busy=0, frameTick=0, memWe=0, memAddr=0, wrReady=0.
  - State is IDLE, the clear counter is 0 and the stale flag is 1, which forces a display fetch after reset.
- Slot priority, evaluated each cycle:
  1. Display fetch, when dispAddress differs from fetchedAddr or stale=1.
  2. Clear write.
  3. Writer write.
- Display fetch timing:
  - Cycle N: memAddr=dispAddress, memWe=0; fetchedAddr is set to dispAddress and stale is cleared.
  - Cycle N+1: dispData is loaded from memRdata and is visible from N+2.
  - Latency is 2 cycles from an address change.
- Coherence: any write (writer or clear) whose address equals fetchedAddr sets stale=1.
  - This covers a write issued in the cycle right after a read of the same address; the byte is then refetched.
- Writer handshake, no FIFO:
  - wrReady = IDLE && !fetchPending && !clrReq && !rst_btn.
  - On acceptance in the same cycle: memWe=1, memAddr=wrAddr, memWdata=wrData.
- Bandwidth: the screen changes address at most once per 17 cycles, so the writer is guaranteed at least 15 of every 17 slots while IDLE.
- State machine:
  - IDLE -> CLEAR on clrReq; latch clrValue, counter=0, busy=1.
  - CLEAR: each non-display slot writes clrValue to address counter, then increments counter.
  - After writing address 1023: -> IDLE, and busy=0 on the next cycle.
  - clrReq during CLEAR is ignored.
  - wrReady=0 throughout CLEAR.
  - clrReq together with wrValid in IDLE: clear wins, and the write is not accepted that cycle.
- frameTick: one-cycle pulse, registered, when dispAddress goes from 1023 to 0 (tracked against the previous-cycle address).
- Reset mid-clear aborts the clear with no further writes; the RAM contents are left partially cleared.

Optional Feature:
FB_WRITE_FIFO_EN: adds a WR_FIFO_DEPTH write buffer in front of the writer slot.
- wrReady = !fifoFull, independent of display fetches and of CLEAR.
- The FIFO drains one entry per writer slot.
- clrReq while the FIFO is non-empty: busy=1 immediately, and the clear starts only once the FIFO is empty.
- Entries accepted during CLEAR are written after the clear completes.

Without the macro there is no buffer and the direct handshake above applies.

Decomposition:
- Shared package: FB_DEPTH, FB_ADDR_W=10, FB_DATA_W=8, state encodings IDLE/CLEAR, and the 1023 last-address constant.
- Sub-module fb_write_fifo (synchronous FIFO with full/empty) is instantiated only under FB_WRITE_FIFO_EN.

Test Plan:
1. Reset, mem[5]=0xA5, dispAddress=5 -> cycle 1: memAddr=5, memWe=0; dispData=0xA5 by cycle 3.
2. dispAddress stable; wrValid, wrAddr=0x010, wrData=0x3C -> wrReady=1 with memWe=1, memAddr=0x010, memWdata=0x3C in the same cycle.
3. dispAddress changes to 7 in the same cycle as wrValid to address 9 -> read granted and wrReady=0; the write is accepted the following cycle.
4. dispAddress=7 settled; write 0x55 to address 7 -> stale set, refetch issued, dispData=0x55 within 3 cycles.
5. clrReq, clrValue=0xFF, scan running -> busy=1; 1024 writes interleaved with display fetches; all RAM bytes read back 0xFF; wrReady=0 throughout; busy falls.
6. dispAddress steps 1022, 1023, 0, 1 -> frameTick high for exactly one cycle, after the 1023->0 transition.

Source files
------------

// File: rtl/fb_arbiter_pkg.sv
// Shared constants and types for the framebuffer arbiter.
// Optional build macro used by the arbiter: FB_WRITE_FIFO_EN.
package fb_arbiter_pkg;

    localparam int FB_DEPTH_DEFAULT = 1024;   // 128x64 pixels, 8 pixels per byte
    localparam int FB_ADDR_W        = 10;
    localparam int FB_DATA_W        = 8;

    localparam logic [FB_ADDR_W-1:0] FB_LAST_ADDR = 10'd1023;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } fbState_t;

    // One buffered writer request
    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [FB_DATA_W-1:0] data;
    } fbWrite_t;

endpackage

// File: rtl/fb_write_fifo.sv
// Small synchronous FIFO holding writer requests until a writer slot is free.
// First-word-fall-through: headData is valid whenever empty is low.
module fb_write_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] headData,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] storeReg [DEPTH];
    logic [AW-1:0]    wrPtrReg;
    logic [AW-1:0]    rdPtrReg;
    logic [AW:0]      countReg;
    logic             doPush;
    logic             doPop;

    assign full     = (countReg == (AW+1)'(DEPTH));
    assign empty    = (countReg == '0);
    assign doPush   = push && !full;
    assign doPop    = pop && !empty;
    assign headData = storeReg[rdPtrReg];

    // Entry storage; no reset needed, occupancy is tracked by countReg
    always_ff @(posedge clk) begin
        if (doPush) begin
            storeReg[wrPtrReg] <= pushData;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge clk) begin
        if (srst) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
            countReg <= '0;
        end else begin
            if (doPush) begin
                wrPtrReg <= wrPtrReg + 1'b1;
            end
            if (doPop) begin
                rdPtrReg <= rdPtrReg + 1'b1;
            end
            if (doPush && !doPop) begin
                countReg <= countReg + 1'b1;
            end else if (doPop && !doPush) begin
                countReg <= countReg - 1'b1;
            end
        end
    end

endmodule

// File: rtl/fb_arbiter.sv
// Framebuffer RAM arbiter: display fetch > clear sequencer > writer, one slot per cycle.
// Tracks the last fetched display address and refetches whenever it is overwritten.
// Build option FB_WRITE_FIFO_EN adds a write buffer in front of the writer slot.
module fb_arbiter
    import fb_arbiter_pkg::*;
#(
    parameter int FB_DEPTH      = FB_DEPTH_DEFAULT,
    parameter int WR_FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_btn,
    input  logic [FB_ADDR_W-1:0] dispAddress,
    output logic [FB_DATA_W-1:0] dispData,
    input  logic                 wrValid,
    output logic                 wrReady,
    input  logic [FB_ADDR_W-1:0] wrAddr,
    input  logic [FB_DATA_W-1:0] wrData,
    input  logic                 clrReq,
    input  logic [FB_DATA_W-1:0] clrValue,
    output logic                 busy,
    output logic                 frameTick,
    output logic [FB_ADDR_W-1:0] memAddr,
    output logic                 memWe,
    output logic [FB_DATA_W-1:0] memWdata,
    input  logic [FB_DATA_W-1:0] memRdata
);

    localparam logic [FB_ADDR_W-1:0] CLR_LAST = FB_ADDR_W'(FB_DEPTH - 1);

    if (WR_FIFO_DEPTH < 2 || (WR_FIFO_DEPTH & (WR_FIFO_DEPTH - 1)) != 0) begin : gBadFifoDepth
        $error("fb_arbiter: WR_FIFO_DEPTH must be a power of two and at least 2");
    end

    fbState_t             stateReg,       stateNext;
    logic [FB_ADDR_W-1:0] clrCountReg,    clrCountNext;
    logic [FB_DATA_W-1:0] clrValueReg,    clrValueNext;
    logic [FB_ADDR_W-1:0] fetchedAddrReg, fetchedAddrNext;
    logic                 staleReg,       staleNext;
    logic                 loadReg,        loadNext;
    logic [FB_DATA_W-1:0] dispDataReg;
    logic [FB_ADDR_W-1:0] prevDispAddrReg;
    logic                 frameTickReg;
    logic                 fetchPending;

`ifdef FB_WRITE_FIFO_EN
    logic     fifoFull;
    logic     fifoEmpty;
    logic     fifoPush;
    logic     fifoPop;
    fbWrite_t fifoIn;
    fbWrite_t fifoHead;
    logic     clrPendingReg, clrPendingNext;

    assign fifoIn   = '{addr: wrAddr, data: wrData};
    assign fifoPush = wrValid && wrReady;

    fb_write_fifo #(
        .DEPTH (WR_FIFO_DEPTH),
        .WIDTH ($bits(fbWrite_t))
    ) u_write_fifo (
        .clk      (clk),
        .srst     (rst_btn),
        .push     (fifoPush),
        .pushData (fifoIn),
        .pop      (fifoPop),
        .headData (fifoHead),
        .full     (fifoFull),
        .empty    (fifoEmpty)
    );

    assign busy = (stateReg == CLEAR) || clrPendingReg;
`else
    assign busy = (stateReg == CLEAR);
`endif

    assign fetchPending = staleReg || (dispAddress != fetchedAddrReg);
    assign dispData     = dispDataReg;
    assign frameTick    = frameTickReg;

    // Slot arbitration, RAM port drive, clear sequencing and coherence tracking
    always_comb begin
        stateNext       = stateReg;
        clrCountNext    = clrCountReg;
        clrValueNext    = clrValueReg;
        fetchedAddrNext = fetchedAddrReg;
        staleNext       = staleReg;
        loadNext        = 1'b0;
        memAddr         = '0;
        memWe           = 1'b0;
        memWdata        = '0;
        wrReady         = 1'b0;
`ifdef FB_WRITE_FIFO_EN
        fifoPop         = 1'b0;
        clrPendingNext  = clrPendingReg;
`endif
        if (!rst_btn) begin
`ifdef FB_WRITE_FIFO_EN
            wrReady = !fifoFull;
`else
            wrReady = (stateReg == IDLE) && !fetchPending && !clrReq;
`endif
            if (fetchPending) begin
                // Display read always wins; data lands in dispData two cycles later
                memAddr         = dispAddress;
                fetchedAddrNext = dispAddress;
                staleNext       = 1'b0;
                loadNext        = 1'b1;
            end else if (stateReg == CLEAR) begin
                memWe        = 1'b1;
                memAddr      = clrCountReg;
                memWdata     = clrValueReg;
                clrCountNext = clrCountReg + 10'd1;
                if (clrCountReg == CLR_LAST) begin
                    stateNext = IDLE;
                end
            end else begin
`ifdef FB_WRITE_FIFO_EN
                if (!fifoEmpty) begin
                    fifoPop  = 1'b1;
                    memWe    = 1'b1;
                    memAddr  = fifoHead.addr;
                    memWdata = fifoHead.data;
                end
`else
                if (wrValid && wrReady) begin
                    memWe    = 1'b1;
                    memAddr  = wrAddr;
                    memWdata = wrData;
                end
`endif
            end

            // A write over the byte currently shown forces a refetch
            if (memWe && (memAddr == fetchedAddrReg)) begin
                staleNext = 1'b1;
            end

`ifdef FB_WRITE_FIFO_EN
            // Buffered writes already accepted go out before the clear starts
            if (stateReg == IDLE) begin
                if (clrPendingReg) begin
                    if (fifoEmpty) begin
                        stateNext      = CLEAR;
                        clrCountNext   = '0;
                        clrPendingNext = 1'b0;
                    end
                end else if (clrReq) begin
                    clrValueNext = clrValue;
                    if (fifoEmpty) begin
                        stateNext    = CLEAR;
                        clrCountNext = '0;
                    end else begin
                        clrPendingNext = 1'b1;
                    end
                end
            end
`else
            if ((stateReg == IDLE) && clrReq) begin
                stateNext    = CLEAR;
                clrCountNext = '0;
                clrValueNext = clrValue;
            end
`endif
        end
    end

    // State registers, display data capture and frame-start detection
    always_ff @(posedge clk) begin
        if (rst_btn) begin
            stateReg        <= IDLE;
            clrCountReg     <= '0;
            clrValueReg     <= '0;
            fetchedAddrReg  <= '0;
            staleReg        <= 1'b1;
            loadReg         <= 1'b0;
            dispDataReg     <= '0;
            prevDispAddrReg <= '0;
            frameTickReg    <= 1'b0;
`ifdef FB_WRITE_FIFO_EN
            clrPendingReg   <= 1'b0;
`endif
        end else begin
            stateReg        <= stateNext;
            clrCountReg     <= clrCountNext;
            clrValueReg     <= clrValueNext;
            fetchedAddrReg  <= fetchedAddrNext;
            staleReg        <= staleNext;
            loadReg         <= loadNext;
            if (loadReg) begin
                dispDataReg <= memRdata;
            end
            prevDispAddrReg <= dispAddress;
            frameTickReg    <= (prevDispAddrReg == FB_LAST_ADDR) && (dispAddress == '0);
`ifdef FB_WRITE_FIFO_EN
            clrPendingReg   <= clrPendingNext;
`endif
        end
    end

endmodule
